// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer; master drives load and control, slave is the timer.
// Flow control is the load_valid/load_ready pair; everything else is level or pulse signalling.
interface countdown_timer_if #(
    parameter int WIDTH = 32
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_value;
    logic             auto_reload;
    logic             start;
    logic             pause;
    logic             stop;
    logic             clear_done;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             expired;
    logic             done;

    modport master (
        output load_valid, load_value, auto_reload, start, pause, stop, clear_done,
        input  load_ready, count, busy, expired, done
    );

    modport slave (
        input  load_valid, load_value, auto_reload, start, pause, stop, clear_done,
        output load_ready, count, busy, expired, done
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter timer with one-shot/auto-reload modes and a tick prescaler; expiry is N*PRESCALE
// cycles after RUN entry. Loads are refused (load_ready=0) only while running.
module countdown_timer #(
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 1
) (
    input  logic              clock,
    input  logic              reset,
    countdown_timer_if.slave  tif
);
    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             busy_q, busy_d;
    logic             expired_q, expired_d;
    logic             done_q, done_d;
    logic             load_acc;
    logic             tick;
    logic             last;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            presc_q   <= '0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            presc_q   <= presc_d;
            busy_q    <= busy_d;
            expired_q <= expired_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        presc_d   = presc_q;
        expired_d = 1'b0;
        load_acc  = tif.load_valid && (state_q != RUN);
        tick      = (state_q == RUN) && (presc_q == PRE_MAX);
        // A zero count can only reach RUN by a load while paused; treat it as terminal too.
        last      = (count_q <= WIDTH'(1));

        if (load_acc) begin
            count_d  = tif.load_value;
            reload_d = tif.load_value;
        end

        case (state_q)
            IDLE: begin
                if (tif.stop) begin
                    presc_d = '0;
                end else if (tif.start && (count_q != '0)) begin
                    state_d = RUN;
                    presc_d = '0;
                end
            end
            RUN: begin
                if (tif.stop) begin
                    state_d = IDLE;
                    presc_d = '0;
                end else if (tif.pause) begin
                    state_d = PAUSED;
                end else begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        if (last) begin
                            expired_d = 1'b1;
                            if (tif.auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = IDLE;
                            end
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end
            end
            PAUSED: begin
                if (tif.stop) begin
                    state_d = IDLE;
                    presc_d = '0;
                end else if (!tif.pause && tif.start) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = expired_d || (done_q && !tif.clear_done);
    end

    assign tif.load_ready = (state_q != RUN);
    assign tif.count      = count_q;
    assign tif.busy       = busy_q;
    assign tif.expired    = expired_q;
    assign tif.done       = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: vector table on a PRESCALE=1 timer, then a hand-written prescaler/phase sequence
// on a PRESCALE=4 timer; expectations go through a scoreboard queue.
module tb_countdown_timer;
    logic clock = 1'b0;
    logic rst1  = 1'b1;
    logic rst4  = 1'b1;

    always #5 clock = ~clock;

    countdown_timer_if #(.WIDTH(32)) if1 ();
    countdown_timer_if #(.WIDTH(32)) if4 ();

    countdown_timer #(.WIDTH(32), .PRESCALE(1)) dut1 (.clock(clock), .reset(rst1), .tif(if1.slave));
    countdown_timer #(.WIDTH(32), .PRESCALE(4)) dut4 (.clock(clock), .reset(rst4), .tif(if4.slave));

    // ctl = {reset, load_valid, auto_reload, start, pause, stop, clear_done}
    // flg = {busy, expired, done, load_ready}, values seen after the edge
    localparam logic [6:0] N = 7'b0000000;
    localparam logic [6:0] R = 7'b1000000;
    localparam logic [6:0] L = 7'b0100000;
    localparam logic [6:0] A = 7'b0010000;
    localparam logic [6:0] S = 7'b0001000;
    localparam logic [6:0] P = 7'b0000100;
    localparam logic [6:0] T = 7'b0000010;
    localparam logic [6:0] C = 7'b0000001;

    typedef struct {
        logic [6:0]  ctl;
        logic [31:0] lval;
        logic [31:0] cnt;
        logic [3:0]  flg;
    } vec_t;

    typedef struct {
        logic [31:0] cnt;
        logic [3:0]  flg;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_err = 0;
    int   n_chk = 0;

    function automatic vec_t mk(input logic [6:0] c, input int lv, input int cnt, input logic [3:0] f);
        vec_t v;
        v.ctl  = c;
        v.lval = 32'(lv);
        v.cnt  = 32'(cnt);
        v.flg  = f;
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0d, expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input bit sel, input int idx);
        exp_t        e;
        logic [31:0] a_cnt;
        logic [3:0]  a_flg;
        if (sel) begin
            rst4            = v.ctl[6];
            if4.load_valid  = v.ctl[5];
            if4.auto_reload = v.ctl[4];
            if4.start       = v.ctl[3];
            if4.pause       = v.ctl[2];
            if4.stop        = v.ctl[1];
            if4.clear_done  = v.ctl[0];
            if4.load_value  = v.lval;
        end else begin
            rst1            = v.ctl[6];
            if1.load_valid  = v.ctl[5];
            if1.auto_reload = v.ctl[4];
            if1.start       = v.ctl[3];
            if1.pause       = v.ctl[2];
            if1.stop        = v.ctl[1];
            if1.clear_done  = v.ctl[0];
            if1.load_value  = v.lval;
        end
        e.cnt = v.cnt;
        e.flg = v.flg;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        if (sel) begin
            a_cnt = if4.count;
            a_flg = {if4.busy, if4.expired, if4.done, if4.load_ready};
        end else begin
            a_cnt = if1.count;
            a_flg = {if1.busy, if1.expired, if1.done, if1.load_ready};
        end
        check("count",      idx, a_cnt,             e.cnt);
        check("busy",       idx, 32'(a_flg[3]),     32'(e.flg[3]));
        check("expired",    idx, 32'(a_flg[2]),     32'(e.flg[2]));
        check("done",       idx, 32'(a_flg[1]),     32'(e.flg[1]));
        check("load_ready", idx, 32'(a_flg[0]),     32'(e.flg[0]));
    endtask

    initial begin
        if1.load_valid = 0; if1.load_value = '0; if1.auto_reload = 0; if1.start = 0;
        if1.pause = 0; if1.stop = 0; if1.clear_done = 0;
        if4.load_valid = 0; if4.load_value = '0; if4.auto_reload = 0; if4.start = 0;
        if4.pause = 0; if4.stop = 0; if4.clear_done = 0;

        // reset, then one-shot from 5
        tbl.push_back(mk(R, 0, 0, 4'b0001));
        tbl.push_back(mk(R, 0, 0, 4'b0001));
        tbl.push_back(mk(L, 5, 5, 4'b0001));
        tbl.push_back(mk(S, 0, 5, 4'b1000));
        tbl.push_back(mk(N, 0, 4, 4'b1000));
        tbl.push_back(mk(N, 0, 3, 4'b1000));
        tbl.push_back(mk(N, 0, 2, 4'b1000));
        tbl.push_back(mk(N, 0, 1, 4'b1000));
        tbl.push_back(mk(N, 0, 0, 4'b0111));
        tbl.push_back(mk(N, 0, 0, 4'b0011));
        tbl.push_back(mk(C, 0, 0, 4'b0001));
        // auto-reload from 3 for 12 cycles, then stop keeps the count
        tbl.push_back(mk(L | A, 3, 3, 4'b0001));
        tbl.push_back(mk(S | A, 0, 3, 4'b1000));
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk(A, 0, 2, (k == 0) ? 4'b1000 : 4'b1010));
            tbl.push_back(mk(A, 0, 1, (k == 0) ? 4'b1000 : 4'b1010));
            tbl.push_back(mk(A, 0, 3, 4'b1110));
        end
        tbl.push_back(mk(T, 0, 3, 4'b0011));
        tbl.push_back(mk(C, 0, 3, 4'b0001));
        // pause at 7 for 5 cycles, resume, stop at 4
        tbl.push_back(mk(L, 10, 10, 4'b0001));
        tbl.push_back(mk(S, 0, 10, 4'b1000));
        tbl.push_back(mk(N, 0, 9, 4'b1000));
        tbl.push_back(mk(N, 0, 8, 4'b1000));
        tbl.push_back(mk(N, 0, 7, 4'b1000));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(P, 0, 7, 4'b0001));
        tbl.push_back(mk(S, 0, 7, 4'b1000));
        tbl.push_back(mk(N, 0, 6, 4'b1000));
        tbl.push_back(mk(N, 0, 5, 4'b1000));
        tbl.push_back(mk(N, 0, 4, 4'b1000));
        tbl.push_back(mk(T, 0, 4, 4'b0001));
        // zero-count start, start+stop, load during RUN
        tbl.push_back(mk(L, 0, 0, 4'b0001));
        tbl.push_back(mk(S, 0, 0, 4'b0001));
        tbl.push_back(mk(L, 6, 6, 4'b0001));
        tbl.push_back(mk(S | T, 0, 6, 4'b0001));
        tbl.push_back(mk(S, 0, 6, 4'b1000));
        tbl.push_back(mk(L, 99, 5, 4'b1000));
        tbl.push_back(mk(N, 0, 4, 4'b1000));
        tbl.push_back(mk(T, 0, 4, 4'b0001));
        tbl.push_back(mk(N, 0, 4, 4'b0001));
        // done set beats a simultaneous clear_done
        tbl.push_back(mk(L, 1, 1, 4'b0001));
        tbl.push_back(mk(S, 0, 1, 4'b1000));
        tbl.push_back(mk(C, 0, 0, 4'b0111));
        tbl.push_back(mk(C, 0, 0, 4'b0001));
        // load+start together: start judges the old count
        tbl.push_back(mk(L | S, 8, 8, 4'b0001));
        tbl.push_back(mk(L | S, 2, 2, 4'b1000));
        tbl.push_back(mk(N, 0, 1, 4'b1000));
        tbl.push_back(mk(N, 0, 0, 4'b0111));
        // reset mid-run clears everything including done
        tbl.push_back(mk(L, 4, 4, 4'b0011));
        tbl.push_back(mk(S, 0, 4, 4'b1010));
        tbl.push_back(mk(N, 0, 3, 4'b1010));
        tbl.push_back(mk(R, 0, 0, 4'b0001));
        tbl.push_back(mk(S, 0, 0, 4'b0001));

        foreach (tbl[i]) apply(tbl[i], 1'b0, i);

        // PRESCALE=4: load 2 -> one decrement every 4 cycles, expiry 8 cycles after RUN entry
        apply(mk(R, 0, 0, 4'b0001), 1'b1, 100);
        apply(mk(L, 2, 2, 4'b0001), 1'b1, 101);
        apply(mk(S, 0, 2, 4'b1000), 1'b1, 102);
        for (int k = 0; k < 3; k++) apply(mk(N, 0, 2, 4'b1000), 1'b1, 103 + k);
        for (int k = 0; k < 4; k++) apply(mk(N, 0, 1, 4'b1000), 1'b1, 106 + k);
        apply(mk(N, 0, 0, 4'b0111), 1'b1, 110);

        // pause with the prescaler at 2: after resume only 2 more cycles to the next tick
        apply(mk(L | C, 2, 2, 4'b0001), 1'b1, 111);
        apply(mk(S, 0, 2, 4'b1000), 1'b1, 112);
        apply(mk(N, 0, 2, 4'b1000), 1'b1, 113);
        apply(mk(N, 0, 2, 4'b1000), 1'b1, 114);
        for (int k = 0; k < 3; k++) apply(mk(P, 0, 2, 4'b0001), 1'b1, 115 + k);
        apply(mk(S, 0, 2, 4'b1000), 1'b1, 118);
        apply(mk(N, 0, 2, 4'b1000), 1'b1, 119);
        for (int k = 0; k < 4; k++) apply(mk(N, 0, 1, 4'b1000), 1'b1, 120 + k);
        apply(mk(N, 0, 0, 4'b0111), 1'b1, 124);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
